// File: rtl/buyruk_bellegi_ws.sv
// Instruction memory with a request/valid fetch port, programmable wait states and a loader port.
// Optional fetch counter on getirme_sayisi when BUYRUK_SAYAC_EN is defined.
module buyruk_bellegi_ws #(
  parameter int unsigned       DEPTH       = 128,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] INIT_WORD   = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              istek,
  input  logic [31:0]       ps,
  output logic              hazir,
  output logic              gecerli,
  output logic [DATA_W-1:0] buyruk,
  output logic              hata,
  input  logic              yaz_en,
  input  logic [31:0]       yaz_adres,
  input  logic [DATA_W-1:0] yaz_veri
`ifdef BUYRUK_SAYAC_EN
  ,
  output logic [31:0]       getirme_sayisi
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] BOS   = 2'd0;
  localparam logic [1:0] BEKLE = 2'd1;
  localparam logic [1:0] CEVAP = 2'd2;

  localparam logic [2:0] SAYAC_YUK = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: INIT_WORD};

  logic [1:0]        r_durum;
  logic [1:0]        w_durum_d;
  logic [2:0]        r_sayac;
  logic [2:0]        w_sayac_d;
  logic [31:0]       r_adres;
  logic [DATA_W-1:0] r_buyruk;
  logic              r_hata;

  logic              w_kabul;
  logic              w_cevaba_gir;
  logic [31:0]       w_oku_adres;
  logic [AW-1:0]     w_oku_indeks;
  logic              w_oku_hatali;
  logic [AW-1:0]     w_yaz_indeks;
  logic              w_yaz_gecerli;

  assign hazir   = (r_durum != BEKLE);
  assign gecerli = (r_durum == CEVAP);
  assign buyruk  = r_buyruk;
  assign hata    = r_hata;

  assign w_kabul = istek & hazir;

  // Without wait states the read happens on the accepting edge, so ps is used directly.
  assign w_oku_adres  = (WAIT_STATES == 0) ? ps : r_adres;
  assign w_oku_indeks = w_oku_adres[AW+1:2];
  assign w_oku_hatali = (|w_oku_adres[1:0]) | (|w_oku_adres[31:AW+2]);

  assign w_yaz_indeks  = yaz_adres[AW+1:2];
  assign w_yaz_gecerli = yaz_en & ~(|yaz_adres[1:0]) & ~(|yaz_adres[31:AW+2]);

  always_comb begin
    w_durum_d    = r_durum;
    w_sayac_d    = r_sayac;
    w_cevaba_gir = 1'b0;
    case (r_durum)
      BOS, CEVAP: begin
        if (w_kabul) begin
          if (WAIT_STATES == 0) begin
            w_durum_d    = CEVAP;
            w_cevaba_gir = 1'b1;
          end else begin
            w_durum_d = BEKLE;
            w_sayac_d = SAYAC_YUK;
          end
        end else begin
          w_durum_d = BOS;
        end
      end
      BEKLE: begin
        if (r_sayac == 3'd0) begin
          w_durum_d    = CEVAP;
          w_cevaba_gir = 1'b1;
        end else begin
          w_sayac_d = r_sayac - 3'd1;
        end
      end
      default: w_durum_d = BOS;
    endcase
  end

  // Loader writes ignore rst and land alongside any read (read sees the old word).
  always_ff @(posedge clk) begin
    if (w_yaz_gecerli) begin
      r_mem[w_yaz_indeks] <= yaz_veri;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_durum  <= BOS;
      r_sayac  <= 3'd0;
      r_buyruk <= INIT_WORD;
      r_hata   <= 1'b0;
    end else begin
      r_durum <= w_durum_d;
      r_sayac <= w_sayac_d;
      if (w_kabul) begin
        r_adres <= ps;
      end
      if (w_cevaba_gir) begin
        if (w_oku_hatali) begin
          r_buyruk <= INIT_WORD;
          r_hata   <= 1'b1;
        end else begin
          r_buyruk <= r_mem[w_oku_indeks];
          r_hata   <= 1'b0;
        end
      end
    end
  end

`ifdef BUYRUK_SAYAC_EN
  logic [31:0] r_getirme;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_getirme <= 32'd0;
    end else if (w_cevaba_gir) begin
      r_getirme <= r_getirme + 32'd1;
    end
  end

  assign getirme_sayisi = r_getirme;
`endif

endmodule

// File: tb/tb_buyruk_bellegi_ws.sv
// Scoreboard bench: instance A has no wait states, instance B has three.
module tb_buyruk_bellegi_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_istek, a_hazir, a_gecerli, a_hata, a_yaz_en;
  logic [31:0] a_ps, a_buyruk, a_yaz_adres, a_yaz_veri;
  logic        b_istek, b_hazir, b_gecerli, b_hata, b_yaz_en;
  logic [31:0] b_ps, b_buyruk, b_yaz_adres, b_yaz_veri;
`ifdef BUYRUK_SAYAC_EN
  logic [31:0] a_sayi, b_sayi;
`endif

  int total = 0;
  int bad   = 0;
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [31:0] mdl_a[128];
  logic [31:0] mdl_b[128];
  logic [32:0] ea, eb;

  buyruk_bellegi_ws #(.DEPTH(128), .DATA_W(32), .WAIT_STATES(0), .INIT_WORD(32'h00000013)) u_a (
`ifdef BUYRUK_SAYAC_EN
    .getirme_sayisi(a_sayi),
`endif
    .clk(clk), .rst(rst), .istek(a_istek), .ps(a_ps), .hazir(a_hazir), .gecerli(a_gecerli),
    .buyruk(a_buyruk), .hata(a_hata), .yaz_en(a_yaz_en), .yaz_adres(a_yaz_adres),
    .yaz_veri(a_yaz_veri)
  );

  buyruk_bellegi_ws #(.DEPTH(128), .DATA_W(32), .WAIT_STATES(3), .INIT_WORD(32'h00000013)) u_b (
`ifdef BUYRUK_SAYAC_EN
    .getirme_sayisi(b_sayi),
`endif
    .clk(clk), .rst(rst), .istek(b_istek), .ps(b_ps), .hazir(b_hazir), .gecerli(b_gecerli),
    .buyruk(b_buyruk), .hata(b_hata), .yaz_en(b_yaz_en), .yaz_adres(b_yaz_adres),
    .yaz_veri(b_yaz_veri)
  );

  // Response monitors: every gecerli pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (a_gecerli === 1'b1) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_spurious_gecerli got buyruk=%h hata=%b required no response", a_buyruk, a_hata);
      end else begin
        ea = qa.pop_front();
        if ({a_hata, a_buyruk} !== ea) begin
          bad++;
          $display("FAIL a_response got hata=%b buyruk=%h required hata=%b buyruk=%h",
                   a_hata, a_buyruk, ea[32], ea[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_gecerli === 1'b1) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_spurious_gecerli got buyruk=%h hata=%b required no response", b_buyruk, b_hata);
      end else begin
        eb = qb.pop_front();
        if ({b_hata, b_buyruk} !== eb) begin
          bad++;
          $display("FAIL b_response got hata=%b buyruk=%h required hata=%b buyruk=%h",
                   b_hata, b_buyruk, eb[32], eb[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic a_load(input logic [31:0] adr, input logic [31:0] d);
    a_yaz_en = 1'b1; a_yaz_adres = adr; a_yaz_veri = d;
    @(posedge clk); #1;
    a_yaz_en = 1'b0;
    if (adr[1:0] == 2'b00 && adr < 32'd512) mdl_a[adr[8:2]] = d;
  endtask

  task automatic b_load(input logic [31:0] adr, input logic [31:0] d);
    b_yaz_en = 1'b1; b_yaz_adres = adr; b_yaz_veri = d;
    @(posedge clk); #1;
    b_yaz_en = 1'b0;
    if (adr[1:0] == 2'b00 && adr < 32'd512) mdl_b[adr[8:2]] = d;
  endtask

  task automatic a_drain();
    int n = 0;
    while (qa.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (qa.size() != 0) begin
      total++; bad++;
      $display("FAIL a_timeout got %0d pending required 0", qa.size());
      qa.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic b_drain();
    int n = 0;
    while (qb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (qb.size() != 0) begin
      total++; bad++;
      $display("FAIL b_timeout got %0d pending required 0", qb.size());
      qb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic a_fetch(input logic [31:0] adr);
    if (adr[1:0] != 2'b00 || adr >= 32'd512) qa.push_back({1'b1, 32'h00000013});
    else qa.push_back({1'b0, mdl_a[adr[8:2]]});
    a_istek = 1'b1; a_ps = adr;
    @(posedge clk); #1;
    a_istek = 1'b0;
    a_drain();
  endtask

  task automatic b_fetch(input logic [31:0] adr);
    if (adr[1:0] != 2'b00 || adr >= 32'd512) qb.push_back({1'b1, 32'h00000013});
    else qb.push_back({1'b0, mdl_b[adr[8:2]]});
    b_istek = 1'b1; b_ps = adr;
    @(posedge clk); #1;
    b_istek = 1'b0;
    b_drain();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (a_hazir !== 1'b1) begin bad++; $display("FAIL reset_a_hazir got %b required 1", a_hazir); end
    total++; if (a_gecerli !== 1'b0) begin bad++; $display("FAIL reset_a_gecerli got %b required 0", a_gecerli); end
    total++; if (a_buyruk !== 32'h00000013) begin bad++; $display("FAIL reset_a_buyruk got %h required 00000013", a_buyruk); end
    total++; if (a_hata !== 1'b0) begin bad++; $display("FAIL reset_a_hata got %b required 0", a_hata); end
    total++; if (b_hazir !== 1'b1) begin bad++; $display("FAIL reset_b_hazir got %b required 1", b_hazir); end
    total++; if (b_gecerli !== 1'b0) begin bad++; $display("FAIL reset_b_gecerli got %b required 0", b_gecerli); end
    total++; if (b_buyruk !== 32'h00000013) begin bad++; $display("FAIL reset_b_buyruk got %h required 00000013", b_buyruk); end
    total++; if (b_hata !== 1'b0) begin bad++; $display("FAIL reset_b_hata got %b required 0", b_hata); end
`ifdef BUYRUK_SAYAC_EN
    total++; if (b_sayi !== 32'd0) begin bad++; $display("FAIL reset_b_sayi got %0d required 0", b_sayi); end
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    a_load(32'd0, 32'h01430313);
    a_istek = 1'b1; a_ps = 32'd0;
    qa.push_back({1'b0, 32'h01430313});
    @(posedge clk); #1;
    a_istek = 1'b0;
    @(negedge clk);
    total++; if (a_gecerli !== 1'b1) begin bad++; $display("FAIL zero_wait_latency got gecerli=%b required 1", a_gecerli); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (a_gecerli !== 1'b0) begin bad++; $display("FAIL zero_wait_pulse got gecerli=%b required 0", a_gecerli); end
    total++; if (a_buyruk !== 32'h01430313) begin bad++; $display("FAIL zero_wait_hold got %h required 01430313", a_buyruk); end
    @(posedge clk); #1;
  endtask

  task automatic test_same_edge_a();
    a_istek = 1'b1; a_ps = 32'd4;
    a_yaz_en = 1'b1; a_yaz_adres = 32'd4; a_yaz_veri = 32'hcafe0001;
    qa.push_back({1'b0, mdl_a[1]});
    @(posedge clk); #1;
    a_istek = 1'b0; a_yaz_en = 1'b0;
    mdl_a[1] = 32'hcafe0001;
    a_drain();
    a_fetch(32'd4);
  endtask

  task automatic test_back_to_back();
    int k, got, cyc, last;
    logic [31:0] prog [8];
    prog = '{32'h01430313, 32'hff628293, 32'h00a00513, 32'h00b50533,
             32'h40a58633, 32'h00c6a023, 32'h0006a703, 32'h00100073};
    for (int i = 0; i < 8; i++) b_load(32'(i * 4), prog[i]);
    k = 1; got = 0; cyc = 0; last = -1;
    b_istek = 1'b1; b_ps = 32'd0;
    qb.push_back({1'b0, mdl_b[0]});
    while (got < 8 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (b_gecerli === 1'b1) begin
        got++;
        if (last >= 0) begin
          total++;
          if (cyc - last != 4) begin bad++; $display("FAIL b2b_interval got %0d required 4", cyc - last); end
        end
        last = cyc;
        if (k < 8) begin
          b_ps = 32'(k * 4);
          qb.push_back({1'b0, mdl_b[k]});
          k++;
        end else begin
          b_istek = 1'b0;
        end
      end else if (cyc > 1) begin
        total++;
        if (b_hazir !== 1'b0) begin bad++; $display("FAIL b2b_hazir_bekle got %b required 0", b_hazir); end
      end
    end
    total++; if (got != 8) begin bad++; $display("FAIL b2b_count got %0d required 8", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_faults();
    b_fetch(32'h00000202);
    b_fetch(32'd512);
    b_fetch(32'h00000001);
    b_load(32'h000001fc, 32'h0badf00d);
    b_fetch(32'h000001fc);
    b_load(32'd6, 32'hdeadbeef);
    b_fetch(32'd4);
    b_load(32'd512, 32'hbadc0ffe);
    b_fetch(32'd0);
  endtask

  task automatic test_late_write();
    b_istek = 1'b1; b_ps = 32'd8;
    qb.push_back({1'b0, 32'hfe50cee3});
    @(posedge clk); #1;
    b_istek = 1'b0;
    b_yaz_en = 1'b1; b_yaz_adres = 32'd8; b_yaz_veri = 32'hfe50cee3;
    @(posedge clk); #1;
    b_yaz_en = 1'b0;
    mdl_b[2] = 32'hfe50cee3;
    b_drain();
  endtask

  task automatic test_same_edge_b();
    b_istek = 1'b1; b_ps = 32'd12;
    qb.push_back({1'b0, mdl_b[3]});
    @(posedge clk); #1;
    b_istek = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    b_yaz_en = 1'b1; b_yaz_adres = 32'd12; b_yaz_veri = 32'h00000073;
    @(posedge clk); #1;
    b_yaz_en = 1'b0;
    mdl_b[3] = 32'h00000073;
    b_drain();
    b_fetch(32'd12);
  endtask

  task automatic test_rst_mid_fetch();
    int seen = 0;
    b_istek = 1'b1; b_ps = 32'd0;
    @(posedge clk); #1;
    b_istek = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    b_yaz_en = 1'b1; b_yaz_adres = 32'd20; b_yaz_veri = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b0; b_yaz_en = 1'b0;
    mdl_b[5] = 32'h12345678;
    @(negedge clk);
    total++; if (b_hazir !== 1'b1) begin bad++; $display("FAIL rst_mid_hazir got %b required 1", b_hazir); end
`ifdef BUYRUK_SAYAC_EN
    total++; if (b_sayi !== 32'd0) begin bad++; $display("FAIL rst_mid_sayi got %0d required 0", b_sayi); end
`endif
    repeat (6) begin
      @(negedge clk);
      if (b_gecerli === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_dropped got %0d pulses required 0", seen); end
    @(posedge clk); #1;
    b_fetch(32'd20);
    b_fetch(32'd0);
    b_fetch(32'd4);
    b_fetch(32'h00000202);
    b_fetch(32'd8);
`ifdef BUYRUK_SAYAC_EN
    total++; if (b_sayi !== 32'd5) begin bad++; $display("FAIL count_after_five got %0d required 5", b_sayi); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mdl_a[i] = 32'h00000013;
      mdl_b[i] = 32'h00000013;
    end
    rst = 1'b1;
    a_istek = 1'b0; a_ps = 32'd0; a_yaz_en = 1'b0; a_yaz_adres = 32'd0; a_yaz_veri = 32'd0;
    b_istek = 1'b0; b_ps = 32'd0; b_yaz_en = 1'b0; b_yaz_adres = 32'd0; b_yaz_veri = 32'd0;
    test_reset();
    test_zero_wait();
    test_same_edge_a();
    test_back_to_back();
    test_faults();
    test_late_write();
    test_same_edge_b();
    test_rst_mid_fetch();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
